// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and position type, used by the sync
// generator and by renderers for screen bounds.
package vga_timing_pkg;

   localparam int POS_W = 10;

   localparam int VGA_H_DISPLAY = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_DISPLAY = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam bit VGA_SYNC_POL  = 1'b0;

   typedef logic [POS_W-1:0] pos_t;

   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the VGA beam: wrapping position counter plus lookahead decodes
// (wrap/disp/sync) of the position the counter moves to on the next edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL      = VGA_H_TOTAL,
   parameter int DISP       = VGA_H_DISPLAY,
   parameter int SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT,
   parameter int SYNC_LEN   = VGA_H_SYNC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [POS_W-1:0] pos,
   output logic             wrap,
   output logic             disp,
   output logic             sync
);

   localparam pos_t LAST       = pos_t'(TOTAL - 1);
   localparam pos_t DISP_END   = pos_t'(DISP);
   localparam pos_t SYNC_FIRST = pos_t'(SYNC_START);
   localparam pos_t SYNC_LAST  = pos_t'(SYNC_START + SYNC_LEN - 1);

   pos_t pos_next;

   // Decodes describe pos_next so the top can register them in step with pos.
   always_comb begin
      pos_next = pos;
      wrap     = 1'b0;
      if (reset) begin
         pos_next = LAST;
      end else if (advance) begin
         if (pos == LAST) begin
            pos_next = '0;
            wrap     = 1'b1;
         end else begin
            pos_next = pos + 1'b1;
         end
      end
      disp = (pos_next < DISP_END);
      sync = (pos_next >= SYNC_FIRST) && (pos_next <= SYNC_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos <= LAST;
      end else begin
         pos <= pos_next;
      end
   end

endmodule

// File: rtl/vga_hvsync_gen.sv
// Free-running VGA timing generator: beam position, blanking, sync and strobes.
// Optional frame_count output enabled by defining VGA_HVSYNC_FRAME_CNT_EN.
module vga_hvsync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = VGA_H_DISPLAY,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_DISPLAY = VGA_V_DISPLAY,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter bit SYNC_POL  = VGA_SYNC_POL
) (
   input  logic             clk,
   input  logic             reset,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             display_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_HVSYNC_FRAME_CNT_EN
   ,
   output logic [7:0]       frame_count
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   logic h_wrap, h_disp, h_sync;
   logic v_wrap, v_disp, v_sync;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .DISP       (H_DISPLAY),
      .SYNC_START (H_DISPLAY + H_FRONT),
      .SYNC_LEN   (H_SYNC)
   ) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (1'b1),
      .pos     (hpos),
      .wrap    (h_wrap),
      .disp    (h_disp),
      .sync    (h_sync)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .DISP       (V_DISPLAY),
      .SYNC_START (V_DISPLAY + V_FRONT),
      .SYNC_LEN   (V_SYNC)
   ) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (h_wrap),
      .pos     (vpos),
      .wrap    (v_wrap),
      .disp    (v_disp),
      .sync    (v_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         display_on  <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         display_on  <= h_disp & v_disp;
         hsync       <= sync_level(h_sync, SYNC_POL);
         vsync       <= sync_level(v_sync, SYNC_POL);
         line_start  <= h_wrap;
         frame_start <= h_wrap & v_wrap;
      end
   end

`ifdef VGA_HVSYNC_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
      end else if (h_wrap && v_wrap) begin
         frame_count <= frame_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Bench for vga_hvsync_gen: a standard 640x480 instance plus a shrunken-timing
// active-high-sync instance, both checked every cycle against a position model.
module tb_vga_hvsync_gen;
   import vga_timing_pkg::*;

   localparam int SH_D = 6, SH_F = 1, SH_S = 3, SH_B = 2;
   localparam int SV_D = 5, SV_F = 1, SV_S = 2, SV_B = 2;
   localparam int S_FRAME = (SH_D + SH_F + SH_S + SH_B) * (SV_D + SV_F + SV_S + SV_B);

   logic clk = 1'b0;
   logic rst_std = 1'b1;
   logic rst_small = 1'b1;
   logic run_chk = 1'b0;
   int   n_std = 0;
   int   n_small = 0;
   int   n_asserts = 0;
   int   n_fail = 0;

   logic [POS_W-1:0] s_hpos, s_vpos, m_hpos, m_vpos;
   logic s_disp, s_hs, s_vs, s_ls, s_fs;
   logic m_disp, m_hs, m_vs, m_ls, m_fs;
`ifdef VGA_HVSYNC_FRAME_CNT_EN
   logic [7:0] s_fc, m_fc;
`endif

   always #5 clk = ~clk;

   vga_hvsync_gen dut_std (
      .clk (clk), .reset (rst_std), .hpos (s_hpos), .vpos (s_vpos),
      .display_on (s_disp), .hsync (s_hs), .vsync (s_vs),
      .line_start (s_ls), .frame_start (s_fs)
`ifdef VGA_HVSYNC_FRAME_CNT_EN
      , .frame_count (s_fc)
`endif
   );

   vga_hvsync_gen #(
      .H_DISPLAY (SH_D), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
      .V_DISPLAY (SV_D), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B),
      .SYNC_POL  (1'b1)
   ) dut_small (
      .clk (clk), .reset (rst_small), .hpos (m_hpos), .vpos (m_vpos),
      .display_on (m_disp), .hsync (m_hs), .vsync (m_vs),
      .line_start (m_ls), .frame_start (m_fs)
`ifdef VGA_HVSYNC_FRAME_CNT_EN
      , .frame_count (m_fc)
`endif
   );

   typedef struct {
      int h; int v; bit d; bit hs; bit vs; bit ls; bit fs; int fc;
   } exp_t;

   // n = non-reset edges since the last reset edge; n==0 is the reset state,
   // which is the last pixel of a frame, so the same arithmetic covers it.
   function automatic exp_t model(input int hd, hf, hsn, hb, vd, vf, vsn, vb,
                                  input bit pol, input int n);
      exp_t e;
      int ht, vt, ft, p;
      ht = hd + hf + hsn + hb;
      vt = vd + vf + vsn + vb;
      ft = ht * vt;
      p  = (n == 0) ? ft - 1 : (n - 1) % ft;
      e.h  = p % ht;
      e.v  = p / ht;
      e.d  = (e.h < hd) && (e.v < vd);
      e.hs = ((e.h >= hd + hf) && (e.h < hd + hf + hsn)) ? pol : !pol;
      e.vs = ((e.v >= vd + vf) && (e.v < vd + vf + vsn)) ? pol : !pol;
      e.ls = (e.h == 0);
      e.fs = (p == 0) && (n != 0);
      e.fc = (n == 0) ? 0 : ((n - 1) / ft + 1) % 256;
      return e;
   endfunction

   function automatic exp_t model_std(input int n);
      return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n);
   endfunction

   function automatic exp_t model_small(input int n);
      return model(SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1, n);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      n_std   <= rst_std   ? 0 : n_std + 1;
      n_small <= rst_small ? 0 : n_small + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (run_chk) begin
         e = model_std(n_std);
         chk("std_hpos", 32'(s_hpos), e.h);
         chk("std_vpos", 32'(s_vpos), e.v);
         chk("std_display_on", 32'(s_disp), int'(e.d));
         chk("std_hsync", 32'(s_hs), int'(e.hs));
         chk("std_vsync", 32'(s_vs), int'(e.vs));
         chk("std_line_start", 32'(s_ls), int'(e.ls));
         chk("std_frame_start", 32'(s_fs), int'(e.fs));
`ifdef VGA_HVSYNC_FRAME_CNT_EN
         chk("std_frame_count", 32'(s_fc), e.fc);
`endif
         e = model_small(n_small);
         chk("sm_hpos", 32'(m_hpos), e.h);
         chk("sm_vpos", 32'(m_vpos), e.v);
         chk("sm_display_on", 32'(m_disp), int'(e.d));
         chk("sm_hsync", 32'(m_hs), int'(e.hs));
         chk("sm_vsync", 32'(m_vs), int'(e.vs));
         chk("sm_line_start", 32'(m_ls), int'(e.ls));
         chk("sm_frame_start", 32'(m_fs), int'(e.fs));
`ifdef VGA_HVSYNC_FRAME_CNT_EN
         chk("sm_frame_count", 32'(m_fc), e.fc);
`endif
      end
   end

   initial begin
      exp_t e;
      bit   found;
      int   cnt, rises, falls;
      logic prev_vs;

      // Pin the model against hand-computed positions.
      e = model_std(420000);
      chk("model_frame_end_h", 32'(e.h), 799);
      chk("model_frame_end_v", 32'(e.v), 524);
      e = model_std(420001);
      chk("model_wrap_h", 32'(e.h), 0);
      chk("model_wrap_v", 32'(e.v), 0);
      chk("model_wrap_fs", 32'(e.fs), 1);
      e = model_std(1 + 490 * 800);
      chk("model_vsync_start", 32'(e.vs), 0);

      repeat (3) @(negedge clk);
      run_chk = 1'b1;
      chk("rst_hpos", 32'(s_hpos), 799);
      chk("rst_vpos", 32'(s_vpos), 524);
      chk("rst_disp", 32'(s_disp), 0);
      chk("rst_hsync", 32'(s_hs), 1);
      chk("rst_vsync", 32'(s_vs), 1);
      chk("rst_fs", 32'(s_fs), 0);
      chk("rst_sm_hpos", 32'(m_hpos), 11);
      chk("rst_sm_vpos", 32'(m_vpos), 9);
      chk("rst_sm_hsync", 32'(m_hs), 0);
      rst_std   = 1'b0;
      rst_small = 1'b0;

      for (int c = 1; c <= 1700; c++) begin
         @(negedge clk);
         case (c)
            1: begin
               chk("first_hpos", 32'(s_hpos), 0);
               chk("first_vpos", 32'(s_vpos), 0);
               chk("first_disp", 32'(s_disp), 1);
               chk("first_fs", 32'(s_fs), 1);
               chk("first_ls", 32'(s_ls), 1);
               chk("first_hsync", 32'(s_hs), 1);
               chk("first_vsync", 32'(s_vs), 1);
            end
            640: chk("disp_639", 32'(s_disp), 1);
            641: chk("disp_640", 32'(s_disp), 0);
            656: chk("hsync_655", 32'(s_hs), 1);
            657: chk("hsync_656", 32'(s_hs), 0);
            752: chk("hsync_751", 32'(s_hs), 0);
            753: chk("hsync_752", 32'(s_hs), 1);
            800: chk("ls_799", 32'(s_ls), 0);
            801: begin
               chk("ls_line1", 32'(s_ls), 1);
               chk("vpos_line1", 32'(s_vpos), 1);
            end
            default: ;
         endcase
         rst_small = ($urandom_range(0, 99) < 3);
      end
      rst_small = 1'b0;

      // Reset the small instance in the middle of both sync pulses.
      found = 1'b0;
      for (int c = 0; c < 3 * S_FRAME && !found; c++) begin
         @(negedge clk);
         if (m_hpos == 8 && m_vpos == 6) found = 1'b1;
      end
      chk("wait_mid_sync", 32'(found), 1);
      chk("mid_hsync_active", 32'(m_hs), 1);
      chk("mid_vsync_active", 32'(m_vs), 1);
      rst_small = 1'b1;
      @(negedge clk);
      chk("midrst_hpos", 32'(m_hpos), 11);
      chk("midrst_vpos", 32'(m_vpos), 9);
      chk("midrst_hsync", 32'(m_hs), 0);
      chk("midrst_vsync", 32'(m_vs), 0);
      @(negedge clk);
      chk("hold_hpos", 32'(m_hpos), 11);
      rst_small = 1'b0;
      @(negedge clk);
      chk("resume_hpos", 32'(m_hpos), 0);
      chk("resume_vpos", 32'(m_vpos), 0);
      chk("resume_fs", 32'(m_fs), 1);

      for (int f = 0; f < 2; f++) begin
         cnt = 0; rises = 0; falls = 0; prev_vs = m_vs;
         do begin
            @(negedge clk);
            cnt++;
            if (m_vs && !prev_vs) rises++;
            if (!m_vs && prev_vs) falls++;
            prev_vs = m_vs;
         end while (!m_fs && cnt < 4 * S_FRAME);
         chk("frame_period", 32'(cnt), S_FRAME);
         chk("vsync_rises", 32'(rises), 1);
         chk("vsync_falls", 32'(falls), 1);
      end

`ifdef VGA_HVSYNC_FRAME_CNT_EN
      rst_small = 1'b1;
      @(negedge clk);
      rst_small = 1'b0;
      repeat (256 * S_FRAME + 1) @(negedge clk);
      chk("fc_wrap_fs", 32'(m_fs), 1);
      chk("fc_wrap", 32'(m_fc), 1);
`endif

      @(negedge clk);
      run_chk = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
